// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and default timing constants for the PLL lock sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int unsigned DEF_RST_CYCLES     = 16;
  localparam int unsigned DEF_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_MAX_RETRIES    = 3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  assign dout = s2_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset / lock-qualification sequencer with retry budget
// and downstream reset release.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       sw_restart,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lol_cnt,
  output logic [2:0] state
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  // STABLE runs until the count reaches STABLE_CYCLES, then spends one more edge entering RUN.
  localparam logic [CW-1:0] STB_DONE = CW'(STABLE_CYCLES);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  logic lock_s;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .din   (pll_locked),
    .dout  (lock_s)
  );

  pll_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    lol_q, lol_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_reset_n_q, sys_reset_n_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RESET_PLL;
      cnt_q         <= '0;
      retry_q       <= '0;
      lol_q         <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      lol_q         <= lol_d;
      pll_rst_q     <= pll_rst_d;
      sys_reset_n_q <= sys_reset_n_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lol_d   = lol_q;

    if (sw_restart) begin
      state_d = RESET_PLL;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
          else                   cnt_d   = cnt_q + CW'(1);
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
          end else if (cnt_q == TMO_LAST) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == RETRY_MAX) ? FAULT : RESET_PLL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STB_DONE) begin
            state_d = RUN;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = RESET_PLL;
            lol_d   = sat_inc8(lol_q);
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = RESET_PLL;
      endcase
    end

    // A restart re-enters RESET_PLL even from RESET_PLL, so it must also restart the count.
    if ((state_d != state_q) || sw_restart) cnt_d = '0;

    pll_rst_d     = (state_d == RESET_PLL) || (state_d == FAULT);
    sys_reset_n_d = (state_d == RUN);
    ready_d       = (state_d == RUN);
    fault_d       = (state_d == FAULT);
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset_n = sys_reset_n_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_cnt   = retry_q;
  assign lol_cnt     = lol_q;
  assign state       = state_q;

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- RST_CYCLES, 16: pll_rst assertion length per attempt.
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release.
- TIMEOUT_CYCLES, 65536: maximum WAIT_LOCK dwell per attempt.
- MAX_RETRIES, 3: failed attempts tolerated before FAULT (1..15).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- pll_locked, in, 1: PLL lock indicator, asynchronous to clk.
- sw_restart, in, 1: single-cycle software restart request.
- pll_rst, out, 1: active-high reset to the PLL.
- sys_reset_n, out, 1: active-low reset to downstream logic on the PLL output clocks.
- ready, out, 1: PLL is locked and downstream is released.
- fault, out, 1: retry budget is exhausted.
- retry_cnt, out, 4: failed attempts in the current sequence.
- lol_cnt, out, 8: saturating count of loss-of-lock events seen in RUN.
- state, out, 3: current FSM state encoding.

Function
REQ-004 The block SHALL synchronize pll_locked through two flops to produce lock_s; all decisions SHALL use lock_s only.
REQ-005 The FSM SHALL have the states RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3 and FAULT=4; all outputs SHALL be registered.
REQ-006 In RESET_PLL the block SHALL hold pll_rst=1 for exactly RST_CYCLES cycles, then enter WAIT_LOCK with pll_rst=0.
REQ-007 In WAIT_LOCK, lock_s=1 SHALL cause entry to STABLE on the next edge, with the cycle counter cleared.
REQ-008 If WAIT_LOCK lasts TIMEOUT_CYCLES cycles without lock_s, the block SHALL increment retry_cnt, then enter FAULT if the new value equals MAX_RETRIES, otherwise enter RESET_PLL.
REQ-009 In STABLE the block SHALL count consecutive lock_s=1 cycles; reaching STABLE_CYCLES SHALL enter RUN. A lock_s=0 in STABLE SHALL return to WAIT_LOCK with the timeout counter restarted and retry_cnt unchanged.
REQ-010 Entry to RUN SHALL set sys_reset_n=1 and ready=1 on the same edge and clear retry_cnt.
REQ-011 In RUN, lock_s=0 SHALL, on the next edge:
- enter RESET_PLL;
- drive sys_reset_n=0 and ready=0;
- increment lol_cnt, saturating at 255.
REQ-012 In FAULT the block SHALL hold pll_rst=1, sys_reset_n=0, ready=0 and fault=1 until sw_restart.
REQ-013 sw_restart=1 SHALL, from any state, enter RESET_PLL on the next edge, clear retry_cnt and fault, and drive sys_reset_n=0. It SHALL take precedence over every simultaneous transition, including timeout and lock loss; lol_cnt SHALL NOT increment on that edge.
REQ-014 sys_reset_n SHALL be 0 in every state except RUN; pll_rst SHALL be 1 only in RESET_PLL and FAULT.
REQ-015 Counters SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide and SHALL never wrap; each counter SHALL be cleared on every state entry.

Reset
REQ-016 While reset_n=0, the block SHALL asynchronously force these values:
- state=RESET_PLL, pll_rst=1, sys_reset_n=0;
- ready=0, fault=0;
- retry_cnt=0, lol_cnt=0;
- counters and synchronizer flops to 0.
REQ-017 On reset_n deassertion the block SHALL begin a full RST_CYCLES PLL reset, regardless of the pll_locked level or any state held before reset.

Structure
REQ-018 The state encoding and the default parameter constants SHALL live in the shared package pll_seq_pkg.
REQ-019 The two-flop synchronizer SHALL be a separate sub-module named sync_2ff, instantiated once.

Verification
All scenarios use RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2.
REQ-020 Clean bring-up: release reset, raise pll_locked 10 cycles later -> pll_rst high for exactly 4 cycles, then STABLE, then RUN with sys_reset_n=1 and ready=1 twelve cycles after pll_locked rises (2 sync + 1 entry + 8 stable + 1 entry).
REQ-021 Lock glitch in STABLE: drop pll_locked for 1 cycle after 5 stable cycles -> return to WAIT_LOCK, retry_cnt=0, RUN entered only after 8 fresh consecutive lock cycles.
REQ-022 No lock: hold pll_locked=0 -> two timeouts, retry_cnt=1 then 2, FAULT with fault=1 and pll_rst=1; sw_restart -> RESET_PLL, fault=0, retry_cnt=0.
REQ-023 Loss of lock in RUN: drop pll_locked -> sys_reset_n=0 and ready=0 three edges later, lol_cnt=1, automatic re-sequence reaches RUN; 300 loss events -> lol_cnt=255.
REQ-024 Simultaneous events: sw_restart on the timeout cycle -> RESET_PLL, retry_cnt=0, no FAULT. Mid-STABLE reset_n pulse -> all outputs return to reset values immediately, without waiting for a clk edge.
